// File: rtl/receive_buffer.sv
// receive_buffer: SPART receiver. Oversamples RxD on the 16x baud tick,
// deframes 8N1 characters LSB first and presents the last good byte to the
// processor over the shared tri-state data bus.
module receive_buffer (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  input  logic       RxD,
  output logic       rda,
  output logic       ferr
);

  localparam int unsigned DW = 8;
  localparam int unsigned TW = 4;
  localparam int unsigned BW = 3;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [DW-1:0]   shreg_q, shreg_d;
  logic [DW-1:0]   rx_data_q, rx_data_d;
  logic            rda_q, rda_d;
  logic            ferr_q, ferr_d;
  logic [1:0]      sync_q;
  logic            rxd_s;
  logic            rd_c;

  assign rxd_s = sync_q[1];
  assign rd_c  = iocs & iorw & (ioaddr == 2'b00);

  // Processor read of the receive buffer is purely combinational
  assign databus = rd_c ? rx_data_q : 8'hzz;

  assign rda  = rda_q;
  assign ferr = ferr_q;

  // Two-flop synchronizer for the asynchronous serial line, idles high
  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], RxD};
  end

  // State, counters, shift register and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tick_q    <= TW'(0);
      bit_q     <= BW'(0);
      shreg_q   <= DW'(0);
      rx_data_q <= DW'(0);
      rda_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      rx_data_q <= rx_data_d;
      rda_q     <= rda_d;
      ferr_q    <= ferr_d;
    end
  end

  // Next-state: deframing on baud ticks; a completing good frame beats a read
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    rx_data_d = rx_data_q;
    ferr_d    = ferr_q;
    rda_d     = rd_c ? 1'b0 : rda_q;

    if (enable) begin
      case (state_q)
        IDLE: begin
          if (!rxd_s) begin
            state_d = START;
            tick_d  = TW'(0);
          end
        end
        START: begin
          tick_d = tick_q + TW'(1);
          if (tick_q == TW'(7)) begin
            if (!rxd_s) begin
              state_d = DATA;
              tick_d  = TW'(0);
              bit_d   = BW'(0);
            end else begin
              state_d = IDLE;
            end
          end
        end
        DATA: begin
          tick_d = tick_q + TW'(1);
          if (tick_q == TW'(15)) begin
            shreg_d = {rxd_s, shreg_q[DW-1:1]};
            bit_d   = bit_q + BW'(1);
            tick_d  = TW'(0);
            if (bit_q == BW'(7)) state_d = STOP;
          end
        end
        STOP: begin
          tick_d = tick_q + TW'(1);
          if (tick_q == TW'(15)) begin
            state_d = IDLE;
            tick_d  = TW'(0);
            if (rxd_s) begin
              rx_data_d = shreg_q;
              rda_d     = 1'b1;
              ferr_d    = 1'b0;
            end else begin
              ferr_d    = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_receive_buffer.sv
// Testbench for receive_buffer: directed frames, expectations queued by the
// stimulus thread and checked by an independent negedge monitor.
module tb_receive_buffer;

  localparam logic [7:0] FLOAT = 8'hC3;  // pattern the bench drives when the DUT must release the bus

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       iocs = 1'b0;
  logic       iorw = 1'b0;
  logic [1:0] ioaddr = 2'b00;
  logic       RxD = 1'b1;
  wire  [7:0] databus;
  logic       rda;
  logic       ferr;

  logic       drv = 1'b0;
  logic       probe = 1'b0;
  logic       mon_en = 1'b0;
  logic       done = 1'b0;
  logic [1:0] prev_st = 2'b00;

  logic [9:0] exp_q[$];
  int         vec = 0;
  int         miss = 0;

  logic       m_rda = 1'b0;
  logic       m_ferr = 1'b0;
  logic [7:0] m_data = 8'h00;

  assign databus = drv ? FLOAT : 8'hzz;

  receive_buffer dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .iocs    (iocs),
    .iorw    (iorw),
    .ioaddr  (ioaddr),
    .databus (databus),
    .RxD     (RxD),
    .rda     (rda),
    .ferr    (ferr)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic push(input logic r, input logic f, input logic [7:0] b);
    exp_q.push_back({r, f, b});
  endtask

  // One baud tick; optionally the stop-bit sampling tick with pre/post checks
  task automatic do_tick(input bit stop_pt, input logic stopb, input logic [7:0] d, input bit rd_now);
    repeat (7) @(posedge clk);
    #1 enable = 1'b1;
    if (stop_pt) begin
      if (rd_now) begin
        iocs = 1'b1; iorw = 1'b1; ioaddr = 2'b00;
        push(m_rda, m_ferr, m_data);
      end else begin
        drv = 1'b1; probe = 1'b1;
        push(m_rda, m_ferr, FLOAT);
      end
    end
    @(posedge clk);
    #1 enable = 1'b0; iocs = 1'b0; iorw = 1'b0; drv = 1'b0; probe = 1'b0;
    if (stop_pt) begin
      if (stopb) begin
        m_rda = 1'b1; m_ferr = 1'b0; m_data = d;
      end else begin
        m_ferr = 1'b1;
        if (rd_now) m_rda = 1'b0;
      end
      drv = 1'b1; probe = 1'b1;
      push(m_rda, m_ferr, FLOAT);
      @(posedge clk);
      #1 drv = 1'b0; probe = 1'b0;
    end
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) do_tick(1'b0, 1'b1, 8'h00, 1'b0);
  endtask

  // Non-read bus access: DUT must not drive, status must hold
  task automatic probe_bus(input logic cs, input logic rw, input logic [1:0] a);
    iocs = cs; iorw = rw; ioaddr = a; drv = 1'b1; probe = 1'b1;
    push(m_rda, m_ferr, FLOAT);
    @(posedge clk);
    #1 iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00; drv = 1'b0; probe = 1'b0;
  endtask

  task automatic read_buf();
    iocs = 1'b1; iorw = 1'b1; ioaddr = 2'b00;
    push(m_rda, m_ferr, m_data);
    @(posedge clk);
    #1 iocs = 1'b0; iorw = 1'b0;
    m_rda = 1'b0;
    drv = 1'b1; probe = 1'b1;
    push(m_rda, m_ferr, FLOAT);
    @(posedge clk);
    #1 drv = 1'b0; probe = 1'b0;
  endtask

  task automatic reset_pulse();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    m_rda = 1'b0; m_ferr = 1'b0; m_data = 8'h00;
    drv = 1'b1; probe = 1'b1;
    push(1'b0, 1'b0, FLOAT);
    @(posedge clk);
    #1 drv = 1'b0; probe = 1'b0;
  endtask

  // Serial frame: start, 8 data LSB first, stop; 16 ticks per bit
  task automatic send_frame(input logic [7:0] d, input logic stopb, input bit rd_at_stop, input int abort_at);
    logic [9:0] f;
    f = {stopb, d, 1'b0};
    for (int j = 0; j < 10; j++) begin
      RxD = f[j];
      for (int t = 1; t <= 16; t++) begin
        if (j == abort_at && t == 8) begin
          reset_pulse();
          RxD = 1'b1;
          return;
        end
        do_tick(j == 9 && t == 9, stopb, d, rd_at_stop && j == 9 && t == 9);
      end
    end
    RxD = 1'b1;
  endtask

  // Monitor: one expectation per status change, bus read or probe cycle
  always @(negedge clk) begin
    logic [1:0] cur;
    logic [9:0] act;
    logic [9:0] e;
    logic       rdc;
    cur = {rda, ferr};
    rdc = iocs && iorw && (ioaddr == 2'b00);
    if (mon_en && (cur !== prev_st || rdc || probe)) begin
      act = {rda, ferr, databus};
      vec++;
      if (exp_q.size() == 0) begin
        miss++;
        $display("FAIL unexpected_event t=%0t: got rda/ferr/bus=%b/%b/%h, required no event",
                 $time, rda, ferr, databus);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          miss++;
          $display("FAIL check%0d t=%0t rda/ferr/bus: got %b/%b/%h required %b/%b/%h",
                   vec, $time, act[9], act[8], act[7:0], e[9], e[8], e[7:0]);
        end
      end
    end
    prev_st = cur;
    if (done) begin
      vec++;
      if (exp_q.size() != 0) begin
        miss++;
        $display("FAIL pending_expectations: got %0d unconsumed, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;

    probe_bus(1'b0, 1'b0, 2'b00);            // reset state
    idle_ticks(2);

    send_frame(8'hA5, 1'b1, 1'b0, -1);       // basic receive
    idle_ticks(4);
    read_buf();

    RxD = 1'b0;                              // start-bit glitch
    idle_ticks(4);
    RxD = 1'b1;
    idle_ticks(20);
    probe_bus(1'b0, 1'b0, 2'b00);

    send_frame(8'h3C, 1'b0, 1'b0, -1);       // framing error
    idle_ticks(4);
    read_buf();
    send_frame(8'h39, 1'b1, 1'b0, -1);
    idle_ticks(4);
    read_buf();

    send_frame(8'h11, 1'b1, 1'b0, -1);       // overrun, read collides with completion
    idle_ticks(4);
    send_frame(8'h22, 1'b1, 1'b1, -1);
    idle_ticks(4);
    probe_bus(1'b1, 1'b1, 2'b01);            // wrong address
    probe_bus(1'b1, 1'b0, 2'b00);            // write
    probe_bus(1'b0, 1'b1, 2'b00);            // not selected
    read_buf();

    send_frame(8'h77, 1'b0, 1'b0, -1);       // set ferr before reset
    idle_ticks(4);
    send_frame(8'hFF, 1'b1, 1'b0, 4);        // reset during data bit 3
    idle_ticks(4);
    read_buf();
    send_frame(8'h5A, 1'b1, 1'b0, -1);
    idle_ticks(4);
    read_buf();

    repeat (20) @(posedge clk);
    #1 done = 1'b1;
  end

endmodule

// File: doc/receive_buffer.md
# receive_buffer

Receive half of the SPART (simple UART). It oversamples the asynchronous `RxD` line on the shared baud `enable` tick, deframes 8N1 characters (LSB first), and holds the last good byte in a receive buffer register. The processor reads that register over the tri-state `databus` through the same `iocs`/`iorw`/`ioaddr` bus used by `transmit_buffer`. It sits beside `transmit_buffer` under the SPART top level and shares its clock, reset, baud generator and bus.

## Interface
- No parameters. Frame format is fixed: 8 data bits, no parity, 1 stop bit, 16 `enable` ticks per bit.
- `clk`  input  1  system clock; all state changes on rising edge.
- `rst`  input  1  reset, synchronous and active-high.
- `enable`  input  1  baud tick from the baud generator, one `clk` wide, at 16× bit rate.
- `iocs`  input  1  chip select.
- `iorw`  input  1  1 = processor read, 0 = processor write (writes are ignored by this block).
- `ioaddr`  input  2  register select; 2'b00 = receive buffer, other values are ignored.
- `databus`  inout  8  driven with `rx_data` while `iocs & iorw & (ioaddr==2'b00)`, else 8'hZZ.
- `RxD`  input  1  serial input, idle high, asynchronous to `clk`.
- `rda`  output  1  receive data available.
- `ferr`  output  1  framing error on the last frame.

## Operation
- Synchronizer: `RxD` passes through two flops to produce `rxd_s`. Both flops reset to 1. They update every `clk` cycle, independent of `enable`.
- Bit counters and the shift register advance only in cycles with `enable`=1. `tick_cnt` is 4 bits. `bit_cnt` is 3 bits.
- FSM states and transitions:
  - IDLE: on a tick with `rxd_s`=0, go to START and set `tick_cnt`=0.
  - START: each tick increments `tick_cnt`. On the tick where `tick_cnt`==7, go to DATA if `rxd_s`==0, with `tick_cnt`=0 and `bit_cnt`=0. Otherwise the start was a glitch: return to IDLE with no flag change.
  - DATA: each tick increments `tick_cnt`. On the tick where `tick_cnt`==15, shift `rxd_s` into the MSB of `shreg` (shift right), increment `bit_cnt` and clear `tick_cnt`. After the 8th sample (`bit_cnt`==7), go to STOP.
  - STOP: on the tick where `tick_cnt`==15, sample `rxd_s` and return to IDLE.
    - Sample 1: `rx_data`←`shreg`, `rda`←1, `ferr`←0.
    - Sample 0: `ferr`←1; `rx_data` and `rda` are unchanged.
- Processor read: the bus read is combinational. `rda` clears on the `clk` edge that ends any cycle with `iocs & iorw & (ioaddr==2'b00)`.
- Overrun: a good frame completing while `rda`=1 overwrites `rx_data`, and `rda` stays 1. There is no overrun flag.
- Simultaneous read and good-frame completion in the same cycle: completion wins. `rda`=1 and `rx_data` = new byte. The bus shows the old byte during that cycle.
- `ferr` is sticky until the next good frame or reset. A read does not clear it.

## Timing
- Reset values:
  - State IDLE; `tick_cnt`, `bit_cnt` = 0.
  - `shreg`, `rx_data` = 8'h00.
  - `rda` = 0, `ferr` = 0.
  - Synchronizer flops = 1.
  - `databus` is Z unless the read condition holds.
- Reset mid-frame discards the partial character. The next character is received normally once the line returns high and a fresh falling edge arrives.
- Detect latency: 2 `clk` through the synchronizer, plus up to 1 tick period to enter START.
- Sample points, counted in ticks after the first START tick:
  - Start confirmation at the 8th tick (mid-bit).
  - Data bit k (k = 0..7) at tick 8 + 16(k+1).
  - Stop bit at tick 152.
- `rda`/`ferr` update on the `clk` edge of the stop-bit sampling tick. IDLE is re-entered on the same edge, so a new start bit is accepted on the very next tick.
- `databus` drive turns on and off combinationally with `iocs`/`iorw`/`ioaddr`, with no cycle delay.

## Test plan
- Receive 8'hA5 (frame bits 0,1,0,1,0,0,1,0,1,1) at 16 ticks/bit with `enable` every 8 `clk`. Required: `rda` rises at the mid-stop tick and `ferr`=0. Then read with `iocs`=1, `iorw`=1, `ioaddr`=00: `databus`=8'hA5 in that cycle and `rda`=0 on the next edge.
- Drive `RxD` low for 4 ticks, then high. Required: FSM returns to IDLE, `rda` stays 0, `ferr` stays 0.
- Send 8'h3C with stop bit 0. Required: `ferr`=1, `rda`=0, `rx_data` unchanged. Then send a good 8'h39: `ferr`=0, `rda`=1, read returns 8'h39.
- Send 8'h11 then 8'h22 with no read in between. Required: `rda` stays 1 and the read returns 8'h22. Assert the read in the exact cycle the 8'h22 stop bit is sampled: `rda` must remain 1.
- Assert `rst` during data bit 3 of 8'hFF. Required: all outputs return to reset values on the next edge. A following 8'h5A is received correctly.
- Set `ioaddr`=01 or `iorw`=0 with `rda`=1. Required: `databus` is Z and `rda` stays 1.
